switch_n: RTL and testbench

SWITCH_N -- requirements
Module: switch_n

---
 rtl/switch_n.sv | 125 ++++++++++++
 tb/tb_switch_n.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_n.sv
// switch_n: routes one input packet stream to NUM_PORTS output FIFOs.
// The top address bits select the destination port. Each port has its own FIFO
// and its own ready, so a full port never stalls traffic to another port.
// Optional per-port delivered-packet counters are built only when the
// SWITCH_N_STATS_EN macro is defined.
module switch_n #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        vld,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [DATA_W-1:0]           data,
  output logic                        rdy,
  output logic [NUM_PORTS-1:0]        vld_o,
  output logic [NUM_PORTS*ADDR_W-1:0] addr_o,
  output logic [NUM_PORTS*DATA_W-1:0] data_o,
  input  logic [NUM_PORTS-1:0]        rdy_i,
  input  logic                        stat_clr,
  output logic [NUM_PORTS*16-1:0]     stat_cnt
);

  localparam int unsigned PortW = $clog2(NUM_PORTS);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned EntW  = ADDR_W + DATA_W;
  localparam logic [PtrW:0] CntFull = (PtrW+1)'(FIFO_DEPTH);

  typedef logic [EntW-1:0] entry_t;

  logic [PortW-1:0]                dst;
  logic [NUM_PORTS-1:0]            push, pop;
  logic [NUM_PORTS-1:0][PtrW:0]    cnt_q, cnt_d;
  logic [NUM_PORTS-1:0][PtrW-1:0]  wptr_q, wptr_d;
  logic [NUM_PORTS-1:0][PtrW-1:0]  rptr_q, rptr_d;
  entry_t                          mem_q [NUM_PORTS][FIFO_DEPTH];

  assign dst = addr[ADDR_W-1 -: PortW];

  // Input ready depends only on the addressed FIFO's fill, never on vld or a same-cycle pop.
  always_comb begin
    rdy  = (cnt_q[dst] != CntFull);
    push = '0;
    if (vld && rdy) push[dst] = 1'b1;
    pop  = vld_o & rdy_i;
  end

  // Present each FIFO head; slices are zeroed when the port is empty.
  always_comb begin
    vld_o  = '0;
    addr_o = '0;
    data_o = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      vld_o[k] = (cnt_q[k] != '0);
      if (vld_o[k]) begin
        addr_o[k*ADDR_W +: ADDR_W] = mem_q[k][rptr_q[k]][EntW-1 -: ADDR_W];
        data_o[k*DATA_W +: DATA_W] = mem_q[k][rptr_q[k]][DATA_W-1:0];
      end
    end
  end

  // Pointer and count next-state; pointers wrap naturally at the power-of-2 depth.
  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (push[k]) wptr_d[k] = wptr_q[k] + 1'b1;
      if (pop[k])  rptr_d[k] = rptr_q[k] + 1'b1;
      if (push[k] && !pop[k])      cnt_d[k] = cnt_q[k] + 1'b1;
      else if (!push[k] && pop[k]) cnt_d[k] = cnt_q[k] - 1'b1;
    end
  end

  // FIFO control state with synchronous reset; reset empties every FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Entry storage needs no reset: outputs are masked while a FIFO is empty.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (push[k]) mem_q[k][wptr_q[k]] <= {addr, data};
    end
  end

`ifdef SWITCH_N_STATS_EN
  logic [NUM_PORTS-1:0][15:0] stat_q, stat_d;

  // Saturating per-port pop counters; clear wins over increment.
  always_comb begin
    stat_d = stat_q;
    if (stat_clr) begin
      stat_d = '0;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (pop[k] && stat_q[k] != 16'hFFFF) stat_d[k] = stat_q[k] + 16'd1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_cnt = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_cnt        = '0;
`endif

endmodule

// File: tb/tb_switch_n.sv
// Directed self-checking bench for switch_n with default parameters.
module tb_switch_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        rdy;
  logic [3:0]  vld_o;
  logic [31:0] addr_o;
  logic [63:0] data_o;
  logic [3:0]  rdy_i;
  logic        stat_clr;
  logic [63:0] stat_cnt;

  int n_vec = 0;
  int n_err = 0;

  switch_n dut (
    .clk      (clk),
    .rst      (rst),
    .vld      (vld),
    .addr     (addr),
    .data     (data),
    .rdy      (rdy),
    .vld_o    (vld_o),
    .addr_o   (addr_o),
    .data_o   (data_o),
    .rdy_i    (rdy_i),
    .stat_clr (stat_clr),
    .stat_cnt (stat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dsl(input int k);
    return data_o[k*16 +: 16];
  endfunction

  function automatic logic [7:0] asl(input int k);
    return addr_o[k*8 +: 8];
  endfunction

  logic [7:0] route_addr [4];
  logic [3:0] bp_rdy     [5];
  logic [15:0] bp_exp    [5];

  initial begin
    route_addr = '{8'h05, 8'h45, 8'h85, 8'hC5};
    bp_rdy     = '{4'b1111, 4'b1101, 4'b1111, 4'b1111, 4'b1111};
    bp_exp     = '{16'd1, 16'd2, 16'd2, 16'd3, 16'd4};

    // Reset held two cycles with traffic present.
    rst = 1'b1; vld = 1'b1; addr = 8'h05; data = 16'h1234; rdy_i = 4'hF; stat_clr = 1'b0;
    tick();
    tick();
    chk("reset_vld_o", 64'(vld_o), 64'h0);
    chk("reset_addr_o", 64'(addr_o), 64'h0);
    chk("reset_data_o", data_o, 64'h0);
    chk("reset_stat", stat_cnt, 64'h0);
    rst = 1'b0; vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr = route_addr[i] & 8'hC0;
      #1;
      chk("reset_rdy", 64'(rdy), 64'h1);
    end

    // Routing: one packet per port, each popped the cycle after it appears.
    vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = route_addr[i];
      data = 16'h1111 * 16'(i + 1);
      tick();
      chk("route_vld_o", 64'(vld_o), 64'(4'b0001 << i));
      chk("route_addr", 64'(asl(i)), 64'(route_addr[i]));
      chk("route_data", 64'(dsl(i)), 64'(16'h1111 * 16'(i + 1)));
    end
    vld = 1'b0;
    tick();
    chk("route_drained", 64'(vld_o), 64'h0);

    // Fill port 2 while stalled; other ports still accept.
    rdy_i = 4'b1011; vld = 1'b1; addr = 8'h80;
    for (int i = 0; i < 4; i++) begin
      data = 16'hA0 + 16'(i);
      #1;
      chk("fill_rdy", 64'(rdy), 64'h1);
      tick();
    end
    chk("full_vld_o", 64'(vld_o), 64'b0100);
    chk("full_head", 64'(dsl(2)), 64'hA0);
    data = 16'hA4;
    #1;
    chk("full_rdy", 64'(rdy), 64'h0);
    rdy_i = 4'b1111;
    #1;
    chk("full_rdy_with_pop", 64'(rdy), 64'h0);
    rdy_i = 4'b1011;
    #1;
    tick();
    addr = 8'h00; data = 16'hB0;
    #1;
    chk("iso_rdy", 64'(rdy), 64'h1);
    tick();
    chk("iso_vld_o", 64'(vld_o), 64'b0101);
    chk("iso_data", 64'(dsl(0)), 64'hB0);
    vld = 1'b0; rdy_i = 4'hF;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("drain_vld_o", 64'(vld_o), 64'b0100);
      chk("drain_data", 64'(dsl(2)), 64'(16'hA0 + 16'(i)));
    end
    tick();
    chk("drain_empty", 64'(vld_o), 64'h0);

    // Backpressure ordering on port 1.
    rdy_i = 4'b1101; vld = 1'b1; addr = 8'h40;
    for (int i = 1; i <= 4; i++) begin
      data = 16'(i);
      tick();
    end
    vld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rdy_i = bp_rdy[i];
      #1;
      chk("bp_vld", 64'(vld_o[1]), 64'h1);
      chk("bp_data", 64'(dsl(1)), 64'(bp_exp[i]));
      tick();
    end
    chk("bp_empty", 64'(vld_o), 64'h0);

`ifdef SWITCH_N_STATS_EN
    chk("stat_before_clr", stat_cnt, {16'd1, 16'd5, 16'd5, 16'd2});
`else
    chk("stat_before_clr", stat_cnt, 64'h0);
`endif
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("stat_cleared", stat_cnt, 64'h0);

    // Stream 20 packets through port 3 with simultaneous push and pop.
    rdy_i = 4'hF; vld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      addr = 8'hC0 + 8'(i);
      data = 16'h300 + 16'(i);
      #1;
      chk("wrap_rdy", 64'(rdy), 64'h1);
      tick();
      chk("wrap_vld_o", 64'(vld_o), 64'b1000);
      chk("wrap_addr", 64'(asl(3)), 64'(8'hC0 + 8'(i)));
      chk("wrap_data", 64'(dsl(3)), 64'(16'h300 + 16'(i)));
    end
    vld = 1'b0;
    tick();
    chk("wrap_empty", 64'(vld_o), 64'h0);
`ifdef SWITCH_N_STATS_EN
    chk("wrap_stat", 64'(stat_cnt[63:48]), 64'd20);
`else
    chk("wrap_stat", stat_cnt, 64'h0);
`endif

    // Reset while port 0 holds three entries.
    rdy_i = 4'b1110; vld = 1'b1; addr = 8'h00;
    for (int i = 0; i < 3; i++) begin
      data = 16'hD0 + 16'(i);
      tick();
    end
    chk("pre_rst_vld_o", 64'(vld_o), 64'b0001);
    rst = 1'b1; vld = 1'b0;
    tick();
    chk("mid_rst_vld_o", 64'(vld_o), 64'h0);
    chk("mid_rst_data_o", data_o, 64'h0);
    chk("mid_rst_stat", stat_cnt, 64'h0);
    rst = 1'b0; rdy_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_idle", 64'(vld_o), 64'h0);
    end
    vld = 1'b1; addr = 8'h00; data = 16'hE0;
    tick();
    vld = 1'b0;
    chk("post_rst_vld_o", 64'(vld_o), 64'b0001);
    chk("post_rst_data", 64'(dsl(0)), 64'hE0);
    tick();
    chk("post_rst_empty", 64'(vld_o), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
